// File: rtl/adder_sequencer.sv
// rtl/adder_sequencer.sv - multi-precision add sequencer rippling carry through one W-bit adder slice
// Optional feature macro: ADDER_SEQ_SUB_EN (adds 'sub' input, computes a - b)
module adder_sequencer #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  input  logic               c_in,
`ifdef ADDER_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*WORDS-1:0] sum,
  output logic               c_out,
  output logic               busy
);

  localparam int N    = W * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            c_out_q, c_out_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [W:0]      limb_sum;
  logic            b_inv;
  logic            carry_init;

  // Subtraction is folded into the accept: B is stored inverted and the carry seeded with 1.
  always_comb begin
`ifdef ADDER_SEQ_SUB_EN
    b_inv = sub;
`else
    b_inv = 1'b0;
`endif
    carry_init = b_inv ? 1'b1 : c_in;
  end

  always_comb begin
    limb_sum = {1'b0, a_q[int'(idx_q)*W +: W]}
             + {1'b0, b_q[int'(idx_q)*W +: W]}
             + {{W{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_inv ? ~b : b;
          carry_d = carry_init;
          idx_d   = '0;
          sum_d   = '0;
          c_out_d = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[int'(idx_q)*W +: W] = limb_sum[W-1:0];
        carry_d = limb_sum[W];
        if (idx_q == LAST_IDX) begin
          c_out_d = limb_sum[W];
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        // The handshake edge only returns to IDLE; a new accept waits one cycle.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ADD);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// tb/tb_adder_sequencer.sv - directed self-checking bench for adder_sequencer (W=16, WORDS=4)
module tb_adder_sequencer;

  localparam int W     = 16;
  localparam int WORDS = 4;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        c_out;
  logic        busy;

  int tests;
  int fails;
  int cyc;
  int acc_cyc [3];

  adder_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef ADDER_SEQ_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [63:0] av, input logic [63:0] bv, input logic ci, input logic sb);
    a        = av;
    b        = bv;
    c_in     = ci;
    sub      = sb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_valid, 1'b1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 64'h0);
    chk("rst_c_out", c_out, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Limb-0 carry into limb 1, with exact latency check
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    chk("lat_busy", busy, 1'b1);
    chk("lat_in_ready", in_ready, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lat_not_yet", out_valid, 1'b0);
    end
    @(negedge clk);
    chk("lat_valid_at_4", out_valid, 1'b1);
    chk("t1_sum", sum, 64'h0000_0000_0001_0000);
    chk("t1_c_out", c_out, 1'b0);
    finish_op();
    chk("t1_release", out_valid, 1'b0);
    chk("t1_in_ready", in_ready, 1'b1);

    // Full-width carry ripple
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    wait_done("t2_done");
    chk("t2_sum", sum, 64'h0);
    chk("t2_c_out", c_out, 1'b1);
    finish_op();

    // Mixed pattern with carries on three limb boundaries
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    a = 64'hDEAD_BEEF_DEAD_BEEF;
    b = 64'hFFFF_FFFF_FFFF_FFFF;
    c_in = 1'b1;
    wait_done("t3_done");
    chk("t3_sum", sum, 64'h2222_2222_2222_2211);
    chk("t3_c_out", c_out, 1'b0);
    finish_op();

    // Backpressure with a competing in_valid
    start_op(64'h10, 64'h20, 1'b0, 1'b0);
    wait_done("bp_done");
    a = 64'h100; b = 64'h1; c_in = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_sum", sum, 64'h30);
      chk("bp_c_out", c_out, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_not_accepted", busy, 1'b0);
    chk("bp_in_ready_back", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", busy, 1'b1);
    wait_done("bp2_done");
    chk("bp2_sum", sum, 64'h101);
    finish_op();

    // Reset abort in the middle of ADD
    start_op(64'h5, 64'h6, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_sum", sum, 64'h0);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1'b1);
    start_op(64'h3, 64'h4, 1'b0, 1'b0);
    wait_done("abort_next_done");
    chk("abort_next_sum", sum, 64'h7);
    finish_op();

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      case (i)
        0: begin a = 64'h1; b = 64'h2; end
        1: begin a = 64'hFFFF; b = 64'hFFFF; end
        default: begin a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000; end
      endcase
      c_in = 1'b0;
      in_valid = 1'b1;
      acc_cyc[i] = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      wait_done("b2b_done");
      case (i)
        0: begin chk("b2b0_sum", sum, 64'h3); chk("b2b0_c_out", c_out, 1'b0); end
        1: begin chk("b2b1_sum", sum, 64'h1_FFFE); chk("b2b1_c_out", c_out, 1'b0); end
        default: begin chk("b2b2_sum", sum, 64'h0); chk("b2b2_c_out", c_out, 1'b1); end
      endcase
    end
    chk("b2b_spacing01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
    chk("b2b_spacing12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);
    @(negedge clk);
    out_ready = 1'b0;

`ifdef ADDER_SEQ_SUB_EN
    start_op(64'h5, 64'h7, 1'b0, 1'b1);
    wait_done("sub1_done");
    chk("sub1_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub1_c_out", c_out, 1'b0);
    finish_op();
    start_op(64'h7, 64'h5, 1'b1, 1'b1);
    wait_done("sub2_done");
    chk("sub2_sum", sum, 64'h2);
    chk("sub2_c_out", c_out, 1'b1);
    finish_op();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
